// File: rtl/dpram_model_if.sv
// Dual-port RAM bus: a write port, a read request port and the read return with ECC flags.
// The master drives the strobes, addresses and injection bits; the slave (the RAM) returns the read data.
interface dpram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) ();
    logic                  wr_cs;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  inj_corr;
    logic                  inj_derr;
    logic                  rd_cs;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  ecccorr;
    logic                  eccderr;
    logic                  mem_clear;

    modport master (
        output wr_cs, wr_addr, wr_data, inj_corr, inj_derr,
        output rd_cs, rd_addr, mem_clear,
        input  rd_data, rd_valid, ecccorr, eccderr
    );

    modport slave (
        input  wr_cs, wr_addr, wr_data, inj_corr, inj_derr,
        input  rd_cs, rd_addr, mem_clear,
        output rd_data, rd_valid, ecccorr, eccderr
    );
endinterface

// File: rtl/dpram_model.sv
// Behavioural dual-port RAM with a fixed-latency read pipeline and per-word ECC error tags.
// Reads are never back-pressured; injected tags model corrected and double-error words.
module dpram_model #(
    parameter int                        ADDR_WIDTH  = 8,
    parameter int                        DATA_WIDTH  = 8,
    parameter int                        RD_LATENCY  = 2,
    parameter int                        WRITE_FIRST = 0,
    parameter logic [DATA_WIDTH-1:0]     UNINIT_DATA = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    dpram_if.slave bus
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int PIPE_N = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

    typedef enum logic [1:0] {
        TAG_CLEAN = 2'd0,
        TAG_CORR  = 2'd1,
        TAG_DERR  = 2'd2
    } tag_t;

    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
        $fatal(1, "dpram_model: RD_LATENCY must be within 1..8");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      written;
    tag_t                  tags [DEPTH];

    tag_t                  wr_tag;
    logic                  collide;
    logic                  cap_v;
    logic [DATA_WIDTH-1:0] cap_d;
    tag_t                  cap_t;
    logic                  feed_v;
    logic [DATA_WIDTH-1:0] feed_d;
    tag_t                  feed_t;

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  ecccorr_q;
    logic                  eccderr_q;

    assign wr_tag  = bus.inj_derr ? TAG_DERR : (bus.inj_corr ? TAG_CORR : TAG_CLEAN);
    assign collide = bus.wr_cs && bus.rd_cs && (bus.wr_addr == bus.rd_addr);

    // The read samples the arrays before this edge's write/clear lands, which gives read-old
    // and pre-clear behaviour for free; read-new is a bypass of the incoming write.
    always_comb begin
        cap_v = bus.rd_cs;
        cap_d = UNINIT_DATA;
        cap_t = TAG_CLEAN;
        if (WRITE_FIRST != 0 && collide) begin
            cap_d = bus.wr_data;
            cap_t = wr_tag;
        end else if (written[bus.rd_addr]) begin
            cap_d = mem[bus.rd_addr];
            cap_t = tags[bus.rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_cs) mem[bus.wr_addr] <= bus.wr_data;
    end

    // The write is ordered after the clear so a same-cycle write survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
            for (int i = 0; i < DEPTH; i++) tags[i] <= TAG_CLEAN;
        end else begin
            if (bus.mem_clear) begin
                written <= '0;
                for (int i = 0; i < DEPTH; i++) tags[i] <= TAG_CLEAN;
            end
            if (bus.wr_cs) begin
                written[bus.wr_addr] <= 1'b1;
                tags[bus.wr_addr]    <= wr_tag;
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_direct
        assign feed_v = cap_v;
        assign feed_d = cap_d;
        assign feed_t = cap_t;
    end else begin : g_pipe
        logic                  pipe_v [PIPE_N];
        logic [DATA_WIDTH-1:0] pipe_d [PIPE_N];
        tag_t                  pipe_t [PIPE_N];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_N; i++) begin
                    pipe_v[i] <= 1'b0;
                    pipe_d[i] <= '0;
                    pipe_t[i] <= TAG_CLEAN;
                end
            end else begin
                pipe_v[0] <= cap_v;
                pipe_d[0] <= cap_d;
                pipe_t[0] <= cap_t;
                for (int i = 1; i < PIPE_N; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                    pipe_d[i] <= pipe_d[i-1];
                    pipe_t[i] <= pipe_t[i-1];
                end
            end
        end

        assign feed_v = pipe_v[PIPE_N-1];
        assign feed_d = pipe_d[PIPE_N-1];
        assign feed_t = pipe_t[PIPE_N-1];
    end

    // Output stage: rd_data only moves on a valid read so it holds across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ecccorr_q  <= 1'b0;
            eccderr_q  <= 1'b0;
        end else begin
            rd_valid_q <= feed_v;
            ecccorr_q  <= feed_v && (feed_t == TAG_CORR);
            eccderr_q  <= feed_v && (feed_t == TAG_DERR);
            if (feed_v) begin
                rd_data_q <= (feed_t == TAG_DERR) ? (feed_d ^ DATA_WIDTH'(1)) : feed_d;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ecccorr  = ecccorr_q;
    assign bus.eccderr  = eccderr_q;
endmodule

// File: tb/tb_dpram_model.sv
// Directed bench for dpram_model: two instances (read-old and read-new) share one stimulus stream.
// Expected values are hand-computed from the intended RAM behaviour.
module tb_dpram_model;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    localparam logic [7:0] UNINIT = 8'hEE;

    dpram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
    dpram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();

    dpram_model #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(2), .WRITE_FIRST(0), .UNINIT_DATA(UNINIT)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );

    dpram_model #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(2), .WRITE_FIRST(1), .UNINIT_DATA(UNINIT)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    assign if1.wr_cs     = if0.wr_cs;
    assign if1.wr_addr   = if0.wr_addr;
    assign if1.wr_data   = if0.wr_data;
    assign if1.inj_corr  = if0.inj_corr;
    assign if1.inj_derr  = if0.inj_derr;
    assign if1.rd_cs     = if0.rd_cs;
    assign if1.rd_addr   = if0.rd_addr;
    assign if1.mem_clear = if0.mem_clear;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Every step ends 1 time unit after a rising edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input logic corr, input logic derr);
        if0.wr_cs    = 1'b1;
        if0.wr_addr  = a;
        if0.wr_data  = d;
        if0.inj_corr = corr;
        if0.inj_derr = derr;
        tick();
        if0.wr_cs    = 1'b0;
        if0.inj_corr = 1'b0;
        if0.inj_derr = 1'b0;
    endtask

    task automatic rd_issue(input logic [7:0] a);
        if0.rd_cs   = 1'b1;
        if0.rd_addr = a;
        tick();
        if0.rd_cs   = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic corr, input logic derr);
        check({name, ".valid0"}, 32'(if0.rd_valid), 32'd1);
        check({name, ".valid1"}, 32'(if1.rd_valid), 32'd1);
        check({name, ".data0"},  32'(if0.rd_data),  32'(e0));
        check({name, ".data1"},  32'(if1.rd_data),  32'(e1));
        check({name, ".corr"},   32'(if0.ecccorr),  32'(corr));
        check({name, ".derr"},   32'(if0.eccderr),  32'(derr));
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] e0,
                              input logic [7:0] e1, input logic corr, input logic derr);
        rd_issue(a);
        tick();
        check_out(name, e0, e1, corr, derr);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n         = 1'b0;
        if0.wr_cs     = 1'b0;
        if0.wr_addr   = '0;
        if0.wr_data   = '0;
        if0.inj_corr  = 1'b0;
        if0.inj_derr  = 1'b0;
        if0.rd_cs     = 1'b0;
        if0.rd_addr   = '0;
        if0.mem_clear = 1'b0;
        tick();
        tick();
        check("rst.valid", 32'(if0.rd_valid), 32'd0);
        check("rst.data",  32'(if0.rd_data),  32'd0);
        check("rst.corr",  32'(if0.ecccorr),  32'd0);
        check("rst.derr",  32'(if0.eccderr),  32'd0);
        rst_n = 1'b1;
        tick();

        // uninitialised word
        rd_issue(8'h77);
        check("uninit.early", 32'(if0.rd_valid), 32'd0);
        tick();
        check_out("uninit", UNINIT, UNINIT, 1'b0, 1'b0);

        // basic latency: valid only one edge after the issue edge's successor
        do_write(8'h10, 8'hA5, 1'b0, 1'b0);
        rd_issue(8'h10);
        check("lat.n1_valid", 32'(if0.rd_valid), 32'd0);
        tick();
        check_out("lat.n2", 8'hA5, 8'hA5, 1'b0, 1'b0);
        tick();
        check("lat.n3_valid", 32'(if0.rd_valid), 32'd0);
        check("lat.hold",     32'(if0.rd_data),  32'h0A5);

        // ECC injection, back-to-back reads
        do_write(8'h20, 8'h5A, 1'b1, 1'b0);
        do_write(8'h21, 8'h5A, 1'b1, 1'b1);
        if0.rd_cs   = 1'b1;
        if0.rd_addr = 8'h20;
        tick();
        if0.rd_addr = 8'h21;
        tick();
        if0.rd_cs   = 1'b0;
        check_out("ecc.corr", 8'h5A, 8'h5A, 1'b1, 1'b0);
        tick();
        check_out("ecc.derr", 8'h5B, 8'h5B, 1'b0, 1'b1);
        tick();
        check("ecc.idle_valid", 32'(if0.rd_valid), 32'd0);
        check("ecc.idle_corr",  32'(if0.ecccorr),  32'd0);
        check("ecc.idle_derr",  32'(if0.eccderr),  32'd0);
        check("ecc.idle_hold",  32'(if0.rd_data),  32'h05B);
        do_write(8'h21, 8'h5A, 1'b0, 1'b0);
        read_check("ecc.clean", 8'h21, 8'h5A, 8'h5A, 1'b0, 1'b0);

        // same-address collision
        do_write(8'h40, 8'h11, 1'b0, 1'b0);
        if0.wr_cs   = 1'b1;
        if0.wr_addr = 8'h40;
        if0.wr_data = 8'h22;
        if0.rd_cs   = 1'b1;
        if0.rd_addr = 8'h40;
        tick();
        if0.wr_cs = 1'b0;
        if0.rd_cs = 1'b0;
        tick();
        check_out("coll", 8'h11, 8'h22, 1'b0, 1'b0);
        read_check("coll.after", 8'h40, 8'h22, 8'h22, 1'b0, 1'b0);

        // collision carrying a new double-error tag
        do_write(8'h41, 8'h30, 1'b0, 1'b0);
        if0.wr_cs    = 1'b1;
        if0.wr_addr  = 8'h41;
        if0.wr_data  = 8'h30;
        if0.inj_derr = 1'b1;
        if0.rd_cs    = 1'b1;
        if0.rd_addr  = 8'h41;
        tick();
        if0.wr_cs    = 1'b0;
        if0.inj_derr = 1'b0;
        if0.rd_cs    = 1'b0;
        tick();
        check("colltag.data0", 32'(if0.rd_data), 32'h030);
        check("colltag.derr0", 32'(if0.eccderr), 32'd0);
        check("colltag.data1", 32'(if1.rd_data), 32'h031);
        check("colltag.derr1", 32'(if1.eccderr), 32'd1);

        // mem_clear with same-cycle write (survives) and read (pre-clear)
        do_write(8'h77, 8'hC3, 1'b0, 1'b0);
        do_write(8'h79, 8'h9C, 1'b0, 1'b0);
        if0.mem_clear = 1'b1;
        if0.wr_cs     = 1'b1;
        if0.wr_addr   = 8'h78;
        if0.wr_data   = 8'h66;
        if0.rd_cs     = 1'b1;
        if0.rd_addr   = 8'h79;
        tick();
        if0.mem_clear = 1'b0;
        if0.wr_cs     = 1'b0;
        if0.rd_cs     = 1'b0;
        tick();
        check_out("clr.preread", 8'h9C, 8'h9C, 1'b0, 1'b0);
        read_check("clr.77", 8'h77, UNINIT, UNINIT, 1'b0, 1'b0);
        read_check("clr.78", 8'h78, 8'h66, 8'h66, 1'b0, 1'b0);
        read_check("clr.79", 8'h79, UNINIT, UNINIT, 1'b0, 1'b0);
        read_check("clr.20", 8'h20, UNINIT, UNINIT, 1'b0, 1'b0);

        // streaming: 256 writes then 256 back-to-back reads with no gaps
        for (int i = 0; i < 256; i++) begin
            do_write(8'(i), 8'(i) ^ 8'h3C, 1'b0, 1'b0);
        end
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                if0.rd_cs   = 1'b1;
                if0.rd_addr = 8'(i);
            end else begin
                if0.rd_cs = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check("stream.valid", 32'(if0.rd_valid), 32'd1);
                check("stream.data",  32'(if0.rd_data),  32'(8'(i - 1) ^ 8'h3C));
            end
        end
        tick();
        check("stream.end_valid", 32'(if0.rd_valid), 32'd0);

        // reset while two reads are in flight
        if0.rd_cs   = 1'b1;
        if0.rd_addr = 8'h05;
        tick();
        if0.rd_addr = 8'h06;
        tick();
        if0.rd_cs = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rstmid.valid", 32'(if0.rd_valid), 32'd0);
        check("rstmid.data",  32'(if0.rd_data),  32'd0);
        tick();
        check("rstmid.hold_valid", 32'(if0.rd_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rstmid.after1", 32'(if0.rd_valid), 32'd0);
        tick();
        check("rstmid.after2", 32'(if0.rd_valid), 32'd0);
        read_check("rstmid.uninit", 8'h05, UNINIT, UNINIT, 1'b0, 1'b0);
        do_write(8'h05, 8'h4D, 1'b0, 1'b0);
        rd_issue(8'h05);
        check("rstmid.lat_early", 32'(if0.rd_valid), 32'd0);
        tick();
        check_out("rstmid.read", 8'h4D, 8'h4D, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dpram_model.md
Name: dpram_model

Overview:
- Synthesizable behavioural dual-port RAM that acts as the responding end of the team's dual-port RAM interface.
- It accepts writes on a write port and returns read data after a fixed, parameterised latency on a read port.
- It models ECC corrected and double-error reporting through per-word error tags, which are set by injection inputs.
- It stands in for vendor RAM macros in block-level benches, running alongside the interface checker.

Parameters:
- ADDR_WIDTH, 8, address width; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, data word width.
- RD_LATENCY, 2, clock edges from the rd_cs sample to rd_data valid; legal range 1..8.
- WRITE_FIRST, 0, same-address collision policy: 0 = read-old, 1 = read-new.
- UNINIT_DATA, '0, value returned when reading a word that has never been written.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_cs  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- inj_corr  input  1  when set with wr_cs, tags the written word as single-bit-corrected.
- inj_derr  input  1  when set with wr_cs, tags the written word as double-error; takes priority over inj_corr.
- rd_cs  input  1  read strobe.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  one-cycle pulse that qualifies rd_data and the ECC flags.
- ecccorr  output  1  ECC corrected indication for the current read.
- eccderr  output  1  ECC double error indication for the current read.
- mem_clear  input  1  synchronous pulse that clears all written and tag state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data = 0, rd_valid = 0, ecccorr = 0, eccderr = 0.
  - The read pipeline is flushed; reads in flight are dropped and produce no rd_valid.
  - The written and tag bit arrays are cleared. Data array contents are don't-care.
- Write: on a posedge with wr_cs = 1:
  - mem[wr_addr] <= wr_data and written[wr_addr] <= 1.
  - tag[wr_addr] <= DERR if inj_derr; else CORR if inj_corr; else CLEAN.
  - A later clean write to the same address clears its tag.
- Read issue: on a posedge with rd_cs = 1, stage 0 of a RD_LATENCY-deep shift pipeline captures {valid, data, tag}.
  - If written[rd_addr] = 0, the captured data is UNINIT_DATA and the tag is CLEAN.
  - Back-to-back reads are accepted every cycle; there is no backpressure.
- Read return: the read captured at edge N appears on the outputs after edge N+RD_LATENCY-1, so it is sampled by the consumer at edge N+RD_LATENCY.
  - rd_valid = 1 for exactly one cycle.
  - CLEAN tag: rd_data = stored data, both flags 0.
  - CORR tag: rd_data = stored data (correct), ecccorr = 1.
  - DERR tag: rd_data = stored data with bit 0 inverted, eccderr = 1.
  - ecccorr and eccderr are never both 1.
- Idle cycles: rd_data holds its last value; rd_valid and both flags are 0.
- Collision: wr_cs and rd_cs in the same cycle with wr_addr == rd_addr.
  - WRITE_FIRST = 0: the read captures the old data and old tag.
  - WRITE_FIRST = 1: the read captures wr_data and the new tag, and the word counts as written.
- mem_clear:
  - On the posedge where it is sampled high, written[] and tag[] are cleared.
  - A write in the same cycle is applied after the clear, so that word remains written.
  - A read in the same cycle captures pre-clear state.
  - Reads already in flight are unaffected.
- Address wrap: addresses are full width, so there is no out-of-range case.
- Elaboration: RD_LATENCY outside 1..8 triggers an elaboration-time fatal.

Test Plan:
- Basic latency, RD_LATENCY = 2: write 0xA5 to address 0x10; read 0x10 at edge N -> rd_valid=1 and rd_data=0xA5 sampled at edge N+2; no rd_valid at N+1 or N+3.
- Streaming: write addresses 0..255 with data = addr^0x3C; read 0..255 back-to-back -> 256 consecutive rd_valid pulses with matching data and no gaps.
- ECC injection: write 0x5A to 0x20 with inj_corr; write 0x5A to 0x21 with inj_derr and inj_corr; read both -> first read gives 0x5A with ecccorr=1; second gives 0x5B with eccderr=1 and ecccorr=0.
- Collision: write 0x11 to 0x40; then same-cycle write 0x22 and read of 0x40 -> returns 0x11 with WRITE_FIRST=0, 0x22 with WRITE_FIRST=1.
- Uninitialised and clear: read 0x77 before any write -> returns UNINIT_DATA; write 0x77, pulse mem_clear, read 0x77 -> returns UNINIT_DATA.
- Reset mid-read: issue reads at N and N+1, assert rst_n low between N+1 and N+2 -> no rd_valid afterwards, outputs 0; a read after reset release gives normal latency.
